// File: rtl/res_station_bank.sv
// Reservation-station bank for one functional-unit class of the Tomasulo core.
// Holds dispatched ops, snoops the CDB for pending operands and issues ready entries round-robin.
module res_station_bank #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned TAG_W    = 3,
  parameter int unsigned NUM_RS   = 2,
  parameter int unsigned OP_W     = 3,
  parameter int unsigned TAG_BASE = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Disp_Valid,
  output logic              Disp_Ready,
  output logic [TAG_W-1:0]  Disp_Tag,
  input  logic [OP_W-1:0]   Disp_Op,
  input  logic [DATA_W-1:0] Disp_Vj,
  input  logic [DATA_W-1:0] Disp_Vk,
  input  logic [TAG_W-1:0]  Disp_Qj,
  input  logic [TAG_W-1:0]  Disp_Qk,
  input  logic              CDB_Valid,
  input  logic [TAG_W-1:0]  CDB_Tag,
  input  logic [DATA_W-1:0] CDB_Data,
  output logic              Exec_Valid,
  input  logic              Exec_Ready,
  output logic [OP_W-1:0]   Exec_Op,
  output logic [DATA_W-1:0] Exec_A,
  output logic [DATA_W-1:0] Exec_B,
  output logic [TAG_W-1:0]  Exec_Tag,
  output logic [NUM_RS-1:0] Busy
);

  localparam int unsigned IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_ISSUED} rs_state_e;

  rs_state_e         st_q [NUM_RS];
  rs_state_e         st_d [NUM_RS];
  logic [OP_W-1:0]   op_q [NUM_RS];
  logic [OP_W-1:0]   op_d [NUM_RS];
  logic [DATA_W-1:0] vj_q [NUM_RS];
  logic [DATA_W-1:0] vj_d [NUM_RS];
  logic [DATA_W-1:0] vk_q [NUM_RS];
  logic [DATA_W-1:0] vk_d [NUM_RS];
  logic [TAG_W-1:0]  qj_q [NUM_RS];
  logic [TAG_W-1:0]  qj_d [NUM_RS];
  logic [TAG_W-1:0]  qk_q [NUM_RS];
  logic [TAG_W-1:0]  qk_d [NUM_RS];

  logic [IDX_W-1:0]  rr_q, rr_d;
  logic              exec_valid_q, exec_valid_d;
  logic [OP_W-1:0]   exec_op_q, exec_op_d;
  logic [DATA_W-1:0] exec_a_q, exec_a_d;
  logic [DATA_W-1:0] exec_b_q, exec_b_d;
  logic [TAG_W-1:0]  exec_tag_q, exec_tag_d;

  logic              disp_found;
  logic [IDX_W-1:0]  disp_idx;
  logic              issue_found;
  logic [IDX_W-1:0]  issue_sel;
  int unsigned       cand;
  logic              cdb_hit;

  assign cdb_hit    = CDB_Valid && (CDB_Tag != '0);
  assign Disp_Ready = disp_found;
  assign Exec_Valid = exec_valid_q;
  assign Exec_Op    = exec_op_q;
  assign Exec_A     = exec_a_q;
  assign Exec_B     = exec_b_q;
  assign Exec_Tag   = exec_tag_q;

  // Lowest-index free station takes the next dispatch
  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    Disp_Tag   = '0;
    Busy       = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      Busy[i] = (st_q[IDX_W'(i)] != ST_FREE);
      if (!disp_found && st_q[IDX_W'(i)] == ST_FREE) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
        Disp_Tag   = TAG_W'(TAG_BASE + i);
      end
    end
  end

  // First ready station at or after the round-robin pointer
  always_comb begin
    issue_found = 1'b0;
    issue_sel   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_RS; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= NUM_RS) cand = cand - NUM_RS;
      if (!issue_found && st_q[IDX_W'(cand)] == ST_READY) begin
        issue_found = 1'b1;
        issue_sel   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    st_d         = st_q;
    op_d         = op_q;
    vj_d         = vj_q;
    vk_d         = vk_q;
    qj_d         = qj_q;
    qk_d         = qk_q;
    rr_d         = rr_q;
    exec_valid_d = exec_valid_q;
    exec_op_d    = exec_op_q;
    exec_a_d     = exec_a_q;
    exec_b_d     = exec_b_q;
    exec_tag_d   = exec_tag_q;

    // Operand snoop on waiting stations; own-tag broadcast retires issued ones
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (st_q[IDX_W'(i)] == ST_WAIT && cdb_hit) begin
        if (qj_q[IDX_W'(i)] == CDB_Tag) begin
          vj_d[IDX_W'(i)] = CDB_Data;
          qj_d[IDX_W'(i)] = '0;
        end
        if (qk_q[IDX_W'(i)] == CDB_Tag) begin
          vk_d[IDX_W'(i)] = CDB_Data;
          qk_d[IDX_W'(i)] = '0;
        end
        if (qj_d[IDX_W'(i)] == '0 && qk_d[IDX_W'(i)] == '0) st_d[IDX_W'(i)] = ST_READY;
      end
      if (st_q[IDX_W'(i)] == ST_ISSUED && CDB_Valid && CDB_Tag == TAG_W'(TAG_BASE + i))
        st_d[IDX_W'(i)] = ST_FREE;
    end

    if (!exec_valid_q || Exec_Ready) begin
      exec_valid_d = issue_found;
      if (issue_found) begin
        exec_op_d          = op_q[issue_sel];
        exec_a_d           = vj_q[issue_sel];
        exec_b_d           = vk_q[issue_sel];
        exec_tag_d         = TAG_W'(TAG_BASE + 32'(issue_sel));
        st_d[issue_sel]    = ST_ISSUED;
        rr_d               = (32'(issue_sel) == NUM_RS - 1) ? '0 : issue_sel + IDX_W'(1);
      end
    end

    // Dispatch, capturing an operand broadcast in the same cycle
    if (Disp_Valid && disp_found) begin
      op_d[disp_idx] = Disp_Op;
      if (Disp_Qj != '0 && CDB_Valid && Disp_Qj == CDB_Tag) begin
        vj_d[disp_idx] = CDB_Data;
        qj_d[disp_idx] = '0;
      end else begin
        vj_d[disp_idx] = Disp_Vj;
        qj_d[disp_idx] = Disp_Qj;
      end
      if (Disp_Qk != '0 && CDB_Valid && Disp_Qk == CDB_Tag) begin
        vk_d[disp_idx] = CDB_Data;
        qk_d[disp_idx] = '0;
      end else begin
        vk_d[disp_idx] = Disp_Vk;
        qk_d[disp_idx] = Disp_Qk;
      end
      st_d[disp_idx] = (qj_d[disp_idx] == '0 && qk_d[disp_idx] == '0) ? ST_READY : ST_WAIT;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM_RS; i++) begin
        st_q[IDX_W'(i)] <= ST_FREE;
        op_q[IDX_W'(i)] <= '0;
        vj_q[IDX_W'(i)] <= '0;
        vk_q[IDX_W'(i)] <= '0;
        qj_q[IDX_W'(i)] <= '0;
        qk_q[IDX_W'(i)] <= '0;
      end
      rr_q         <= '0;
      exec_valid_q <= 1'b0;
      exec_op_q    <= '0;
      exec_a_q     <= '0;
      exec_b_q     <= '0;
      exec_tag_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_RS; i++) begin
        st_q[IDX_W'(i)] <= st_d[IDX_W'(i)];
        op_q[IDX_W'(i)] <= op_d[IDX_W'(i)];
        vj_q[IDX_W'(i)] <= vj_d[IDX_W'(i)];
        vk_q[IDX_W'(i)] <= vk_d[IDX_W'(i)];
        qj_q[IDX_W'(i)] <= qj_d[IDX_W'(i)];
        qk_q[IDX_W'(i)] <= qk_d[IDX_W'(i)];
      end
      rr_q         <= rr_d;
      exec_valid_q <= exec_valid_d;
      exec_op_q    <= exec_op_d;
      exec_a_q     <= exec_a_d;
      exec_b_q     <= exec_b_d;
      exec_tag_q   <= exec_tag_d;
    end
  end

endmodule

// File: doc/res_station_bank.md
Name: res_station_bank

Overview:
- Parametrised bank of NUM_RS reservation stations for one functional-unit class in the Tomasulo datapath.
- Sits between unidade_despacho/register_status and the functional unit.
- Accepts dispatched instructions with tagged operands and snoops the CDB to resolve pending operands.
- Issues ready entries to the FU through a registered valid/ready port with round-robin fairness, and frees each entry when its result is broadcast on the CDB.

Parameters:
DATA_W, 16, operand/result width
TAG_W, 3, tag width; tag 0 means "value present"
NUM_RS, 2, number of stations (1..(2^TAG_W)-1-TAG_BASE+1)
OP_W, 3, opcode width
TAG_BASE, 1, tag of station 0; station i owns tag TAG_BASE+i

Ports:
Clock  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Disp_Valid  in  1  dispatch request
Disp_Ready  out  1  at least one station FREE (combinational from state)
Disp_Tag  out  TAG_W  tag of the station that will take the dispatch: lowest-index FREE; 0 if none
Disp_Op  in  OP_W  opcode
Disp_Vj, Disp_Vk  in  DATA_W  operand values, valid when matching Q is 0
Disp_Qj, Disp_Qk  in  TAG_W  producing station tags, 0 = value valid
CDB_Valid  in  1  common data bus broadcast strobe
CDB_Tag  in  TAG_W  producing tag
CDB_Data  in  DATA_W  result value
Exec_Valid  out  1  issue register holds an instruction
Exec_Ready  in  1  FU accepts
Exec_Op  out  OP_W  issued opcode
Exec_A, Exec_B  out  DATA_W  issued operands
Exec_Tag  out  TAG_W  tag of issued station (FU returns it on CDB)
Busy  out  NUM_RS  per-station not-FREE flag

Behaviour:
- Per-station state: FREE, WAIT (a Q nonzero), READY (Qj=Qk=0), ISSUED (sent to FU, awaiting CDB).
- Reset:
  - All stations FREE; Q/V/Op cleared.
  - Exec_Valid=0; Exec_Op/A/B/Tag=0; RR pointer=0; Busy=0.
  - Disp_Ready=1 and Disp_Tag=TAG_BASE in the first cycle after reset.
  - Reset mid-operation discards all entries, including the issue register.
- Dispatch:
  - Occurs at an edge with Disp_Valid&&Disp_Ready.
  - Writes the lowest-index FREE station, which moves to WAIT or READY.
  - Disp_Valid with Disp_Ready=0 is ignored with no state change.
- Dispatch bypass: if a Disp_Qx is nonzero and equals CDB_Tag while CDB_Valid, capture CDB_Data and set Qx=0 in the same edge.
- Snoop: each edge, every WAIT station with Qx==CDB_Tag (CDB_Valid=1, CDB_Tag nonzero) loads Vx=CDB_Data and sets Qx=0.
  - The station becomes READY when both Qs are 0 after the update.
  - Both operands may resolve on one broadcast.
- Issue register:
  - Loaded when (!Exec_Valid || Exec_Ready) and any station was READY before the edge.
  - The selected station is the first READY index at or after the RR pointer, wrapping modulo NUM_RS.
  - That station moves to ISSUED; RR pointer <= selected index + 1 (mod NUM_RS).
  - If no station is READY on a handshake, Exec_Valid drops to 0.
  - Payload is stable while Exec_Valid && !Exec_Ready.
- Latency: dispatch with both operands ready at edge N gives Exec_Valid=1 after edge N+1. An operand resolved by CDB at edge N gives Exec_Valid after edge N+1 at the earliest. There is no same-cycle CDB-to-Exec bypass.
- Free: an ISSUED station whose tag equals CDB_Tag with CDB_Valid=1 goes FREE at that edge. It is not dispatchable in that same cycle, because Disp_Ready reflects pre-edge state.
- Simultaneous events:
  - Dispatch, snoop, issue load and free may occur on one edge; each touches distinct stations or fields.
  - A CDB tag matching a FREE or READY station is ignored for that station.
- Tags outside TAG_BASE..TAG_BASE+NUM_RS-1 never free a local station but are still snooped as operand tags.

Test Plan:
1. Reset, then dispatch Op=1, Vj=5, Vk=7, Q=0 at edge 1 -> Disp_Tag was 1; after edge 2 Exec_Valid=1, Exec_A=5, Exec_B=7, Exec_Tag=1; Busy=01.
2. Dispatch Qj=2, Vk=3; later CDB_Valid, Tag=2, Data=0x00AA -> station READY; next edge Exec_A=0x00AA, Exec_B=3; earlier cycles keep Exec_Valid=0.
3. Dispatch whose Disp_Qj=2 equals the CDB_Tag=2 broadcast in the same cycle -> operand captured, Exec_Valid one edge later.
4. Fill both stations (NUM_RS=2) -> Disp_Ready=0; extra Disp_Valid ignored; CDB Tag=1 frees station 0 -> Disp_Ready=1, Disp_Tag=1 the next cycle.
5. Both stations READY, Exec_Ready held 0 for 3 cycles -> payload constant (Tag=1); Exec_Ready=1 -> next Exec_Tag=2; repeated fills alternate tags 1, 2, 1.
6. Assert Reset while Exec_Valid=1 and one station WAIT -> after edge all outputs 0, Busy=0, Disp_Ready=1.
